// File: rtl/hex_pkg.sv
// Shared types for the hex system: memory word/address
// types and the memory-arbiter port tag and response tag.
package hex_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [31:0] data_t;

  localparam int HEX_MAX_ARB_PORTS = 8;
  localparam int ARB_PORT_W = $clog2(HEX_MAX_ARB_PORTS);

  typedef logic [ARB_PORT_W-1:0] arb_port_t;

  typedef struct packed {
    logic      valid;
    arb_port_t port_id;
  } arb_resp_t;

endpackage

// File: rtl/hex_rr_picker.sv
// One-hot picker: round-robin from i_last+1, or lowest index
// when HEX_ARB_FIXED_PRIO_EN is defined (i_last then unused).
// Ports: i_req (request vector), i_last (last granted index),
// o_gnt (one-hot grant), o_idx (grant index), o_any (any grant).
module hex_rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

`ifdef HEX_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^i_last;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    // Walk downward so the lowest requesting index wins.
    for (int j = N - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = W'(j);
        o_any    = 1'b1;
      end
    end
  end
`else
  int best;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    best  = N;
    // Distance of port j past i_last; the closest requester wins.
    for (int j = 0; j < N; j++) begin
      if (i_req[j] &&
          ((j + N - int'(i_last) - 1) % N) < best) begin
        best     = (j + N - int'(i_last) - 1) % N;
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = W'(j);
        o_any    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/hex_mem_arbiter.sv
// Shares one fixed-latency memory port among NUM_PORTS requesters;
// read responses are routed back to the issuing port in order.
// Ports: i_req_* per-port request, o_req_ready one-hot grant,
// o_res_valid/o_res_data read response, o_mem_* memory request,
// i_mem_data read data MEM_LATENCY cycles after o_mem_valid.
// Build option: HEX_ARB_FIXED_PRIO_EN selects fixed priority.
module hex_mem_arbiter
  import hex_pkg::*;
#(
  parameter  int NUM_PORTS   = 2,
  parameter  int MEM_LATENCY = 1,
  localparam int PORT_W      =
    (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_PORTS-1:0] i_req_valid,
  input  logic [NUM_PORTS-1:0] i_req_we,
  input  addr_t                i_req_addr [NUM_PORTS],
  input  data_t                i_req_data [NUM_PORTS],
  output logic [NUM_PORTS-1:0] o_req_ready,
  output logic [NUM_PORTS-1:0] o_res_valid,
  output data_t                o_res_data,
  output logic                 o_mem_valid,
  output logic                 o_mem_we,
  output addr_t                o_mem_addr,
  output data_t                o_mem_data,
  input  data_t                i_mem_data
);

  logic [NUM_PORTS-1:0] pick_gnt;
  logic [PORT_W-1:0]    pick_idx;
  logic                 pick_any;
  logic                 grant;

  logic [PORT_W-1:0] last_q, last_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  addr_t             mem_addr_q, mem_addr_d;
  data_t             mem_data_q, mem_data_d;
  logic [PORT_W-1:0] iss_port_q, iss_port_d;

  arb_resp_t [MEM_LATENCY-1:0] resp_q, resp_d;
  arb_resp_t                   resp_tail;

  logic [NUM_PORTS-1:0] res_valid_q, res_valid_d;
  data_t                res_data_q, res_data_d;

  hex_rr_picker #(
    .N (NUM_PORTS),
    .W (PORT_W)
  ) u_picker (
    .i_req  (i_req_valid),
    .i_last (last_q),
    .o_gnt  (pick_gnt),
    .o_idx  (pick_idx),
    .o_any  (pick_any)
  );

  // Nothing is accepted while reset is held.
  assign grant       = pick_any & i_rst;
  assign o_req_ready = i_rst ? pick_gnt : '0;
  assign resp_tail   = resp_q[MEM_LATENCY-1];

  always_comb begin
    last_d      = last_q;
    mem_valid_d = grant;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    iss_port_d  = iss_port_q;
    if (grant) begin
      last_d     = pick_idx;
      mem_we_d   = i_req_we[pick_idx];
      mem_addr_d = i_req_addr[pick_idx];
      mem_data_d = i_req_data[pick_idx];
      iss_port_d = pick_idx;
    end

    // Tracker follows the issued request; writes enter as bubbles.
    resp_d = '0;
    resp_d[0].valid   = mem_valid_q & ~mem_we_q;
    resp_d[0].port_id = arb_port_t'(iss_port_q);
    for (int k = 1; k < MEM_LATENCY; k++) begin
      resp_d[k] = resp_q[k-1];
    end

    res_valid_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      res_valid_d[p] = resp_tail.valid &&
        (resp_tail.port_id == arb_port_t'(p));
    end
    res_data_d = resp_tail.valid ? i_mem_data : res_data_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_q      <= PORT_W'(NUM_PORTS - 1);
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      iss_port_q  <= '0;
      resp_q      <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      last_q      <= last_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      iss_port_q  <= iss_port_d;
      resp_q      <= resp_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // The write strobe only means something alongside o_mem_valid.
  assign o_mem_valid = mem_valid_q;
  assign o_mem_we    = mem_we_q & mem_valid_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_data  = mem_data_q;
  assign o_res_valid = res_valid_q;
  assign o_res_data  = res_data_q;

endmodule
